// File: rtl/pc_sequencer_pkg.sv
// Shared control-flow encodings and default address map for the fetch front end.
package pc_sequencer_pkg;

    localparam int CPU_ADDR_W = 32;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

    localparam logic [3:0] NPC_OP_SEQ  = 4'd0;
    localparam logic [3:0] NPC_OP_BEQ  = 4'd1;
    localparam logic [3:0] NPC_OP_J    = 4'd2;
    localparam logic [3:0] NPC_OP_JR   = 4'd3;
    localparam logic [3:0] NPC_OP_BNE  = 4'd4;
    localparam logic [3:0] NPC_OP_BGEZ = 4'd5;
    localparam logic [3:0] NPC_OP_BGTZ = 4'd6;
    localparam logic [3:0] NPC_OP_BLEZ = 4'd7;
    localparam logic [3:0] NPC_OP_BLTZ = 4'd8;

endpackage

// File: rtl/pc_sequencer_if.sv
// D-stage control inputs and F-stage PC outputs of the PC sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              int_req;
    logic              eret;
    logic [ADDR_W-1:0] epc;
    logic [3:0]        npc_op;
    logic [25:0]       imm26;
    logic [ADDR_W-1:0] ra;
    logic              equal;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] link_addr;
    logic              fetch_adel;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        output stall, int_req, eret, epc, npc_op, imm26, ra, equal,
        input  pc, link_addr, fetch_adel, fetch_count
    );

    modport slave (
        input  stall, int_req, eret, epc, npc_op, imm26, ra, equal,
        output pc, link_addr, fetch_adel, fetch_count
    );
endinterface

// File: rtl/pc_sequencer_npc_calc.sv
// Combinational next-PC target for the D-stage control-flow op.
// Latency: zero (pure combinational).
// Backpressure: none; stall/redirect priority lives in the caller.
module npc_calc
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic [3:0]        npc_op,
    input  logic [ADDR_W-1:0] pc,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] ra,
    input  logic              equal,
    output logic [ADDR_W-1:0] target
);
    localparam logic [ADDR_W-1:0] J_KEEP = ~ADDR_W'(32'h0FFF_FFFF);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] j_pc;
    logic              ra_neg;
    logic              ra_zero;

    assign seq_pc  = pc + ADDR_W'(4);
    assign br_pc   = pc + {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};
    assign j_pc    = (pc & J_KEEP) | ADDR_W'({imm26, 2'b00});
    assign ra_neg  = ra[ADDR_W-1];
    assign ra_zero = (ra == '0);

    always_comb begin
        target = seq_pc;
        unique case (npc_op)
            NPC_OP_BEQ:  target = equal              ? br_pc : seq_pc;
            NPC_OP_J:    target = j_pc;
            NPC_OP_JR:   target = ra;
            NPC_OP_BNE:  target = !equal             ? br_pc : seq_pc;
            NPC_OP_BGEZ: target = !ra_neg            ? br_pc : seq_pc;
            NPC_OP_BGTZ: target = (!ra_neg && !ra_zero) ? br_pc : seq_pc;
            NPC_OP_BLEZ: target = (ra_neg || ra_zero)   ? br_pc : seq_pc;
            NPC_OP_BLTZ: target = ra_neg             ? br_pc : seq_pc;
            default:     target = seq_pc;
        endcase
    end
endmodule

// File: rtl/pc_sequencer.sv
// F-stage PC register with exception/eret/stall priority, adel flag and fetch counter.
// Latency: one cycle from any input to pc; link_addr and fetch_adel decode pc only.
// Backpressure: stall holds pc and count; int_req and eret override stall.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(EXC_VEC_DEF),
    parameter logic [ADDR_W-1:0] IM_BASE  = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] IM_SIZE  = ADDR_W'(32'h0000_4000),
    parameter int                CNT_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    // Window bounds carry one extra bit so IM_BASE+IM_SIZE cannot wrap.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, IM_BASE};
    localparam logic [ADDR_W:0] WIN_HI = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  cnt_q;
    logic              advance;

    npc_calc #(.ADDR_W(ADDR_W)) u_npc_calc (
        .npc_op (bus.npc_op),
        .pc     (pc_q),
        .imm26  (bus.imm26),
        .ra     (bus.ra),
        .equal  (bus.equal),
        .target (target)
    );

    always_comb begin
        pc_nxt  = pc_q;
        advance = 1'b0;
        if (bus.int_req) begin
            pc_nxt  = EXC_VEC;
            advance = 1'b1;
        end else if (bus.eret) begin
            pc_nxt  = bus.epc;
            advance = 1'b1;
        end else if (!bus.stall) begin
            pc_nxt  = target;
            advance = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q <= pc_nxt;
            if (advance) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.link_addr   = pc_q + ADDR_W'(4);
    assign bus.fetch_count = cnt_q;
    assign bus.fetch_adel  = (pc_q[1:0] != 2'b00)
                           || ({1'b0, pc_q} < WIN_LO)
                           || ({1'b0, pc_q} >= WIN_HI);
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed cases plus randomized traffic against a reference model.
module tb_pc_sequencer;
    localparam int unsigned RST_PC  = 32'h0000_3000;
    localparam int unsigned EXC_PC  = 32'h0000_4180;
    localparam int unsigned WIN_BASE = 32'h0000_3000;
    localparam int unsigned WIN_SIZE = 32'h0000_4000;

    logic clk = 1'b0;
    logic reset;

    pc_sequencer_if #(.ADDR_W(32), .CNT_W(32)) b  ();
    pc_sequencer_if #(.ADDR_W(32), .CNT_W(4))  b4 ();

    assign b4.stall   = b.stall;
    assign b4.int_req = b.int_req;
    assign b4.eret    = b.eret;
    assign b4.epc     = b.epc;
    assign b4.npc_op  = b.npc_op;
    assign b4.imm26   = b.imm26;
    assign b4.ra      = b.ra;
    assign b4.equal   = b.equal;

    pc_sequencer #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    pc_sequencer #(.ADDR_W(32), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int unsigned m_pc;
    int unsigned m_cnt;
    int unsigned m_cnt4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Architectural next-PC rule for an unstalled cycle.
    function automatic int unsigned ref_target(input int op, input int unsigned pc,
                                               input logic [25:0] imm, input int unsigned ra,
                                               input bit eq);
        int unsigned seq, br;
        bit taken;
        seq = pc + 4;
        br  = pc + int'(unsigned'(int'(signed'(imm[15:0])) * 4));
        taken = 1'b0;
        case (op)
            1: taken = eq;
            2: return (pc & 32'hF000_0000) | (int'(imm) * 4);
            3: return ra;
            4: taken = !eq;
            5: taken = (int'(ra) >= 0);
            6: taken = (int'(ra) > 0);
            7: taken = (int'(ra) <= 0);
            8: taken = (int'(ra) < 0);
            default: taken = 1'b0;
        endcase
        return taken ? br : seq;
    endfunction

    function automatic bit ref_adel(input int unsigned pc);
        return (pc % 4 != 0) || (pc < WIN_BASE)
            || (longint'(pc) >= longint'(WIN_BASE) + longint'(WIN_SIZE));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) begin
            m_pc = RST_PC; m_cnt = 0; m_cnt4 = 0;
        end else if (b.int_req) begin
            m_pc = EXC_PC; m_cnt++; m_cnt4 = (m_cnt4 + 1) % 16;
        end else if (b.eret) begin
            m_pc = b.epc; m_cnt++; m_cnt4 = (m_cnt4 + 1) % 16;
        end else if (!b.stall) begin
            m_pc = ref_target(int'(b.npc_op), m_pc, b.imm26, b.ra, b.equal);
            m_cnt++; m_cnt4 = (m_cnt4 + 1) % 16;
        end
        chk("pc",        b.pc,                 m_pc);
        chk("link_addr", b.link_addr,          m_pc + 4);
        chk("fetch_adel", 32'(b.fetch_adel),   32'(ref_adel(m_pc)));
        chk("fetch_count", b.fetch_count,      m_cnt);
        chk("fetch_count4", 32'(b4.fetch_count), m_cnt4);
    endtask

    task automatic set_op(input int op, input logic [25:0] imm, input logic [31:0] ra, input bit eq);
        reset = 1'b0; b.stall = 1'b0; b.int_req = 1'b0; b.eret = 1'b0;
        b.npc_op = 4'(op); b.imm26 = imm; b.ra = ra; b.equal = eq;
    endtask

    task automatic load_pc(input logic [31:0] val);
        set_op(3, 26'd0, val, 1'b0);
        tick();
    endtask

    logic [3:0]  taken_tbl [3];
    logic [31:0] ra_tbl    [3];
    int unsigned held_pc, held_cnt;

    initial begin
        taken_tbl[0] = 4'b1010; ra_tbl[0] = 32'h0000_0000;
        taken_tbl[1] = 4'b1100; ra_tbl[1] = 32'h0000_0001;
        taken_tbl[2] = 4'b0011; ra_tbl[2] = 32'hFFFF_FFFF;
        m_pc = 0; m_cnt = 0; m_cnt4 = 0;

        // Reset dominates stall and int_req.
        set_op(0, 26'd0, 32'd0, 1'b0);
        reset = 1'b1; b.stall = 1'b1; b.int_req = 1'b1; b.eret = 1'b1; b.epc = 32'h3044;
        tick();
        chk("rst_pc",   b.pc, 32'h3000);
        chk("rst_cnt",  b.fetch_count, 32'd0);
        chk("rst_adel", 32'(b.fetch_adel), 32'd0);
        chk("rst_link", b.link_addr, 32'h3004);

        load_pc(32'h3010);
        set_op(1, 26'h000FFFE, 32'd0, 1'b1);
        tick();
        chk("beq_taken", b.pc, 32'h3008);
        load_pc(32'h3010);
        set_op(1, 26'h000FFFE, 32'd0, 1'b0);
        tick();
        chk("beq_fall", b.pc, 32'h3014);

        load_pc(32'h3020);
        set_op(2, 26'h0000C10, 32'd0, 1'b0);
        tick();
        chk("j_tgt", b.pc, 32'h3040);
        load_pc(32'h3105);
        chk("jr_mis_adel", 32'(b.fetch_adel), 32'd1);
        load_pc(32'h7000);
        chk("jr_hi_adel", 32'(b.fetch_adel), 32'd1);
        load_pc(32'h6FFC);
        chk("jr_top_ok", 32'(b.fetch_adel), 32'd0);

        for (int r = 0; r < 3; r++) begin
            for (int op = 5; op <= 8; op++) begin
                load_pc(32'h3100);
                set_op(op, 26'd4, ra_tbl[r], 1'b0);
                tick();
                chk($sformatf("br_op%0d_ra%0d", op, r), 32'(b.pc == 32'h3110),
                    32'(taken_tbl[r][8 - op]));
            end
        end

        held_pc = m_pc; held_cnt = m_cnt;
        set_op(0, 26'd0, 32'd0, 1'b0);
        b.stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("stall_pc",  b.pc, held_pc);
        chk("stall_cnt", b.fetch_count, held_cnt);
        b.int_req = 1'b1;
        tick();
        chk("int_over_stall", b.pc, 32'h4180);
        chk("int_stall_cnt",  b.fetch_count, held_cnt + 1);
        b.int_req = 1'b0; b.eret = 1'b1; b.epc = 32'h3044;
        tick();
        chk("eret_pc", b.pc, 32'h3044);
        b.int_req = 1'b1;
        tick();
        chk("int_over_eret", b.pc, 32'h4180);

        for (int op = 9; op <= 15; op++) begin
            load_pc(32'h3200);
            set_op(op, 26'h3FFFFFF, 32'hFFFF_FFFF, 1'b1);
            tick();
            chk($sformatf("op%0d_seq", op), b.pc, 32'h3204);
        end

        load_pc(32'hFFFF_FFFC);
        set_op(0, 26'd0, 32'd0, 1'b0);
        tick();
        chk("pc_wrap", b.pc, 32'h0);

        reset = 1'b1;
        tick();
        set_op(0, 26'd0, 32'd0, 1'b0);
        for (int i = 0; i < 17; i++) tick();
        chk("cnt4_wrap", 32'(b4.fetch_count), 32'd1);

        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 99) < 2);
            b.int_req = ($urandom_range(0, 99) < 6);
            b.eret    = ($urandom_range(0, 99) < 6);
            b.stall   = ($urandom_range(0, 99) < 20);
            b.epc     = WIN_BASE + ($urandom_range(0, 32'h0FFF) * 4);
            b.npc_op  = 4'($urandom_range(0, 15));
            b.imm26   = 26'($urandom);
            b.ra      = $urandom_range(0, 1) ? (WIN_BASE + $urandom_range(0, 32'h0FFF) * 4)
                                             : $urandom;
            b.equal   = 1'($urandom_range(0, 1));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
